// File: rtl/float_compare_vec_pkg.sv
// Shared types and helpers for the vector FP32 comparator.
package float_compare_vec_pkg;

  typedef enum logic [2:0] {
    CMP_LT   = 3'd0,
    CMP_LE   = 3'd1,
    CMP_EQ   = 3'd2,
    CMP_GT   = 3'd3,
    CMP_GE   = 3'd4,
    CMP_MIN  = 3'd5,
    CMP_MAX  = 3'd6,
    CMP_RSVD = 3'd7
  } cmp_mode_t;

  localparam logic [7:0] FP32_EXP_ALL_ONES = 8'hFF;
  localparam int         FP32_QNAN_BIT     = 22;

  // Maps an FP32 pattern onto an unsigned key whose integer order matches
  // the numeric order (negatives inverted, positives lifted above them).
  function automatic logic [31:0] fp32_order_key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

endpackage

// File: rtl/float_compare_vec_if.sv
// Operand/result stream bundle for float_compare_vec.
// Carries q_unord only when FLOAT_CMP_UNORDERED_FLAG_EN is defined.
interface float_compare_vec_if #(
  parameter int NUM_LANES = 8
);

  logic [32*NUM_LANES-1:0] in1;
  logic [32*NUM_LANES-1:0] in2;
  logic [2:0]              mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_LANES-1:0]    q;
  logic [32*NUM_LANES-1:0] q_data;
  logic                    q_valid;
  logic                    q_ready;
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
  logic [NUM_LANES-1:0]    q_unord;
`endif

  modport master (
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
    input  q_unord,
`endif
    output in1, in2, mode, in_valid, q_ready,
    input  in_ready, q, q_data, q_valid
  );

  modport slave (
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
    output q_unord,
`endif
    input  in1, in2, mode, in_valid, q_ready,
    output in_ready, q, q_data, q_valid
  );

endinterface

// File: rtl/float_compare_lane.sv
// Combinational single-lane FP32 compare/select (predicates, MIN, MAX).
// The unord port exists only when FLOAT_CMP_UNORDERED_FLAG_EN is defined.
module float_compare_lane
  import float_compare_vec_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  cmp_mode_t   mode,
  output logic        q,
  output logic [31:0] data
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
  ,
  output logic        unord
`endif
);

  logic        nan_a, nan_b, unord_w, both_zero, eq, lt, sel_a;
  logic [31:0] key_a, key_b;

  assign nan_a     = (a[30:23] == FP32_EXP_ALL_ONES) && (a[22:0] != 23'd0);
  assign nan_b     = (b[30:23] == FP32_EXP_ALL_ONES) && (b[22:0] != 23'd0);
  assign unord_w   = nan_a || nan_b;
  assign key_a     = fp32_order_key(a);
  assign key_b     = fp32_order_key(b);
  // +0 and -0 map to different keys, so they are equalised explicitly.
  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
  assign eq        = both_zero || (key_a == key_b);
  assign lt        = !both_zero && (key_a < key_b);

`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
  assign unord = unord_w;
`endif

  always_comb begin
    q     = 1'b0;
    data  = a;
    sel_a = 1'b1;
    case (mode)
      CMP_LE: q = !unord_w && (lt || eq);
      CMP_EQ: q = !unord_w && eq;
      CMP_GT: q = !unord_w && !lt && !eq;
      CMP_GE: q = !unord_w && !lt;
      CMP_MIN, CMP_MAX: begin
        if (nan_a && nan_b)      sel_a = 1'b1;
        else if (nan_a)          sel_a = 1'b0;
        else if (nan_b)          sel_a = 1'b1;
        else if (mode == CMP_MIN) sel_a = lt || eq;
        else                     sel_a = !lt;
        q    = sel_a;
        data = sel_a ? a : b;
        if (nan_a && nan_b) data[FP32_QNAN_BIT] = 1'b1;
      end
      default: q = !unord_w && lt;
    endcase
  end

endmodule

// File: rtl/float_compare_vec.sv
// Pipelined NUM_LANES-wide FP32 comparator with AXI-style backpressure.
// Optional unordered flag output: define FLOAT_CMP_UNORDERED_FLAG_EN.
module float_compare_vec
  import float_compare_vec_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int LATENCY   = 2
) (
  input logic              clk,
  input logic              reset,
  float_compare_vec_if.slave bus
);

  logic                    advance;
  logic [NUM_LANES-1:0]    lane_q;
  logic [32*NUM_LANES-1:0] lane_data;

  logic [LATENCY-1:0]      vld_q, vld_d;
  logic [NUM_LANES-1:0]    q_q    [LATENCY];
  logic [NUM_LANES-1:0]    q_d    [LATENCY];
  logic [32*NUM_LANES-1:0] data_q [LATENCY];
  logic [32*NUM_LANES-1:0] data_d [LATENCY];
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
  logic [NUM_LANES-1:0]    lane_unord;
  logic [NUM_LANES-1:0]    unord_q [LATENCY];
  logic [NUM_LANES-1:0]    unord_d [LATENCY];
`endif

  // The whole pipe moves or holds as one; a full output stage only moves
  // when downstream accepts.
  assign advance      = bus.q_ready || !vld_q[LATENCY-1];
  assign bus.in_ready = advance;
  assign bus.q_valid  = vld_q[LATENCY-1];
  assign bus.q        = q_q[LATENCY-1];
  assign bus.q_data   = data_q[LATENCY-1];
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
  assign bus.q_unord  = unord_q[LATENCY-1];
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    float_compare_lane u_lane (
      .a    (bus.in1[32*i +: 32]),
      .b    (bus.in2[32*i +: 32]),
      .mode (cmp_mode_t'(bus.mode)),
      .q    (lane_q[i]),
      .data (lane_data[32*i +: 32])
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
      ,
      .unord(lane_unord[i])
`endif
    );
  end

  always_comb begin
    vld_d  = vld_q;
    q_d    = q_q;
    data_d = data_q;
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
    unord_d = unord_q;
`endif
    if (advance) begin
      // Stage 0: capture compare results
      vld_d[0]  = bus.in_valid;
      q_d[0]    = lane_q;
      data_d[0] = lane_data;
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
      unord_d[0] = lane_unord;
`endif
      // Stages 1..LATENCY-1: pure delay
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i]  = vld_q[i-1];
        q_d[i]    = q_q[i-1];
        data_d[i] = data_q[i-1];
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
        unord_d[i] = unord_q[i-1];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        q_q[i]    <= '0;
        data_q[i] <= '0;
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
        unord_q[i] <= '0;
`endif
      end
    end else begin
      vld_q  <= vld_d;
      q_q    <= q_d;
      data_q <= data_d;
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
      unord_q <= unord_d;
`endif
    end
  end

endmodule

// File: tb/tb_float_compare_vec.sv
// Self-checking bench for float_compare_vec: directed cases plus a
// queue scoreboard fed from an independent behavioural model.
module tb_float_compare_vec;
  import float_compare_vec_pkg::*;

  localparam int NL  = 8;
  localparam int LAT = 2;

  typedef struct packed {
    logic [NL-1:0]    q;
    logic [32*NL-1:0] d;
    logic [NL-1:0]    u;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  float_compare_vec_if #(.NUM_LANES(NL)) bus ();

  float_compare_vec #(.NUM_LANES(NL), .LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  exp_t sb[$];

  logic [31:0] tbl [15] = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
                            32'h7F80_0000, 32'hFF80_0000, 32'h0000_0001, 32'h8000_0001,
                            32'h7FC0_0000, 32'h7F80_0001, 32'hFFC0_0000, 32'h4000_0000,
                            32'hC000_0000, 32'h007F_FFFF, 32'h3F80_0001};

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Sign/magnitude ordering, written independently of the key trick.
  function automatic exp_t model(input logic [2:0] m, input logic [32*NL-1:0] av,
                                 input logic [32*NL-1:0] bv);
    exp_t r;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      logic [31:0] a, b, d;
      logic lt, eq, na, nb, un, p;
      a = av[32*i +: 32];
      b = bv[32*i +: 32];
      na = is_nan(a);
      nb = is_nan(b);
      un = na || nb;
      if (a[30:0] == 0 && b[30:0] == 0) begin eq = 1; lt = 0; end
      else if (a == b) begin eq = 1; lt = 0; end
      else begin
        eq = 0;
        if (a[31] != b[31]) lt = a[31];
        else if (!a[31])    lt = a[30:0] < b[30:0];
        else                lt = a[30:0] > b[30:0];
      end
      d = a;
      case (m)
        3'd1: p = !un && (lt || eq);
        3'd2: p = !un && eq;
        3'd3: p = !un && !lt && !eq;
        3'd4: p = !un && !lt;
        3'd5, 3'd6: begin
          if (na && nb) begin p = 1; d = a | 32'h0040_0000; end
          else if (na) begin p = 0; d = b; end
          else if (nb) begin p = 1; d = a; end
          else begin
            p = (m == 3'd5) ? (lt || eq) : !lt;
            d = p ? a : b;
          end
        end
        default: p = !un && lt;
      endcase
      r.q[i] = p;
      r.d[32*i +: 32] = d;
      r.u[i] = un;
    end
    return r;
  endfunction

  // Scoreboard monitor, plus stability check of a stalled output.
  initial begin
    logic hold;
    logic [NL-1:0] hq;
    logic [32*NL-1:0] hd;
    exp_t e;
    hold = 0;
    hq = '0;
    hd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 0;
      else begin
        if (hold) begin
          chk("hold_valid", bus.q_valid, 1);
          chk("hold_q", bus.q, hq);
          chk("hold_data", bus.q_data, hd);
        end
        hold = bus.q_valid && !bus.q_ready;
        hq = bus.q;
        hd = bus.q_data;
        if (bus.q_valid && bus.q_ready) begin
          if (sb.size() == 0) chk("sb_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            chk("sb_q", bus.q, e.q);
            chk("sb_data", bus.q_data, e.d);
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
            chk("sb_unord", bus.q_unord, e.u);
`endif
            n_out++;
          end
        end
        if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.mode, bus.in1, bus.in2));
      end
    end
  end

  function automatic logic [32*NL-1:0] vec(input logic [31:0] l0, input logic [31:0] l1,
                                           input int s);
    logic [32*NL-1:0] v;
    v = '0;
    v[31:0]  = l0;
    v[63:32] = l1;
    for (int i = 2; i < NL; i++) v[32*i +: 32] = tbl[(s + 3*i) % 15];
    return v;
  endfunction

  task automatic drive_accept();
    int k;
    k = 0;
    bus.in_valid = 1;
    do begin @(negedge clk); k++; end while (!bus.in_ready && k < 50);
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] m, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1);
    @(posedge clk); #1;
    bus.mode = m;
    bus.in1 = vec(a0, a1, 0);
    bus.in2 = vec(b0, b1, 5);
    drive_accept();
    bus.in_valid = 0;
  endtask

  task automatic wait_out();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.q_valid && k < 50);
    if (!bus.q_valid) chk("output_timeout", 0, 1);
  endtask

  logic drv_done;
  logic [3:0] rdy_pat = 4'b1001;

  task automatic stream(input int n, input bit cyc_mode, input bit rand_rdy);
    int n0, k;
    n0 = n_out;
    drv_done = 0;
    fork
      begin
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
          bus.mode = cyc_mode ? 3'(i % 7) : 3'($urandom_range(0, 7));
          for (int l = 0; l < NL; l++) begin
            bus.in1[32*l +: 32] = ($urandom_range(0, 3) == 0) ? $urandom() : tbl[$urandom_range(0, 14)];
            bus.in2[32*l +: 32] = ($urandom_range(0, 3) == 0) ? $urandom() : tbl[$urandom_range(0, 14)];
          end
          drive_accept();
        end
        bus.in_valid = 0;
        drv_done = 1;
      end
      begin
        int c;
        c = 0;
        while (!drv_done) begin
          bus.q_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_pat[3 - (c % 4)];
          c++;
          @(posedge clk); #1;
        end
        bus.q_ready = 1;
      end
    join
    k = 0;
    while (sb.size() != 0 && k < 60) begin @(negedge clk); k++; end
    chk("stream_count", n_out - n0, n);
    chk("stream_empty", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.mode = 3'd0;
    bus.in_valid = 0;
    bus.q_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_q_valid", bus.q_valid, 0);
    chk("rst_q", bus.q, 0);
    chk("rst_q_data", bus.q_data, 0);
    rst_n = 1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // LT with latency measurement
    send(3'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000);
    @(negedge clk);
    chk("lat_early", bus.q_valid, 0);
    @(negedge clk);
    chk("lat_valid", bus.q_valid, 1);
    chk("lt_lane0", bus.q[0], 1);
    chk("lt_lane1", bus.q[1], 0);

    send(3'd2, 32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h3F80_0000);
    wait_out();
    chk("eq_zero", bus.q[0], 1);
    send(3'd0, 32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h3F80_0000);
    wait_out();
    chk("lt_zero", bus.q[0], 0);
    send(3'd5, 32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h3F80_0000);
    wait_out();
    chk("min_zero_data", bus.q_data[31:0], 32'h0000_0000);
    chk("min_zero_q", bus.q[0], 1);

    for (int m = 0; m < 5; m++) begin
      send(3'(m), 32'h7FC0_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000);
      wait_out();
      chk("nan_pred", bus.q[0], 0);
`ifdef FLOAT_CMP_UNORDERED_FLAG_EN
      chk("nan_unord", bus.q_unord[0], 1);
`endif
    end
    send(3'd5, 32'h7FC0_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000);
    wait_out();
    chk("nan_min_data", bus.q_data[31:0], 32'hBF80_0000);
    chk("nan_min_q", bus.q[0], 0);

    send(3'd6, 32'hFF80_0000, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
    wait_out();
    chk("max_denorm_data", bus.q_data[31:0], 32'h0000_0001);
    chk("max_denorm_q", bus.q[0], 0);

    send(3'd5, 32'h7F80_0001, 32'hFFC0_0000, 32'h3F80_0000, 32'h3F80_0000);
    wait_out();
    chk("min_2nan_data", bus.q_data[31:0], 32'h7FC0_0001);
    chk("min_2nan_q", bus.q[0], 1);

    send(3'd7, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000);
    wait_out();
    chk("rsvd_lt", bus.q[1:0], 2'b01);
    @(posedge clk); #1;

    stream(10, 1'b1, 1'b0);
    stream(40, 1'b0, 1'b1);

    // Reset with two beats in flight
    @(posedge clk); #1;
    bus.mode = 3'd3;
    bus.in1 = vec(32'h4000_0000, 32'h0, 1);
    bus.in2 = vec(32'h3F80_0000, 32'h0, 2);
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.mode = 3'd6;
    @(posedge clk); #1;
    bus.in_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_mid_valid", bus.q_valid, 0);
    chk("rst_mid_data", bus.q_data, 0);
    sb.delete();
    n0 = n_out;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    chk("rst_rel_ready", bus.in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_no_output", bus.q_valid, 0);
    end
    chk("rst_out_count", n_out - n0, 0);
    send(3'd3, 32'h4000_0000, 32'h3F80_0000, 32'h0, 32'h0);
    wait_out();
    chk("post_rst_gt", bus.q[0], 1);
    @(posedge clk); #1;
    repeat (3) @(negedge clk);
    chk("final_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
